// File: rtl/dct4x4_sched_if.sv
// Bundles the feeder, butterfly and result-sink signals of the 4x4 DCT scheduler.
// No latency of its own; the slave side is the scheduler, the master side is its environment.
// Feeder uses valid/ready; the butterfly and sink have no backpressure.
interface dct4x4_sched_if #(
  parameter int WIDTH_X = 16,
  parameter int WIDTH_Y = 22
);
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH_X-1:0] in_x0, in_x1, in_x2, in_x3;
  logic                      bf_load;
  logic signed [WIDTH_Y-1:0] bf_x0, bf_x1, bf_x2, bf_x3;
  logic signed [WIDTH_Y-1:0] bf_y0, bf_y1, bf_y2, bf_y3;
  logic                      out_valid;
  logic [1:0]                out_col;
  logic signed [WIDTH_Y-1:0] out_y0, out_y1, out_y2, out_y3;
  logic                      busy;
  logic                      done;

  modport master (
    output start, in_valid, in_x0, in_x1, in_x2, in_x3, bf_y0, bf_y1, bf_y2, bf_y3,
    input  in_ready, bf_load, bf_x0, bf_x1, bf_x2, bf_x3, out_valid, out_col,
    input  out_y0, out_y1, out_y2, out_y3, busy, done
  );

  modport slave (
    input  start, in_valid, in_x0, in_x1, in_x2, in_x3, bf_y0, bf_y1, bf_y2, bf_y3,
    output in_ready, bf_load, bf_x0, bf_x1, bf_x2, bf_x3, out_valid, out_col,
    output out_y0, out_y1, out_y2, out_y3, busy, done
  );
endinterface

// File: rtl/dct4x4_sched.sv
// Schedules one shared 4-point butterfly through a 4x4 2-D DCT: 4 row passes, transpose, 4 column passes.
// Latency: 4 row handshakes + 2 drain + 4 column + 2 drain + 1 done cycle; each column result is registered.
// Backpressure: rows stall on in_valid (pipe holds); the output side has none, so the sink must take every column.
module dct4x4_sched #(
  parameter int WIDTH_X = 16,
  parameter int WIDTH_Y = 22,
  parameter int SHIFT1  = 7,
  parameter int SHIFT2  = 8
) (
  input logic            clk,
  input logic            rst,
  dct4x4_sched_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_RDRAIN, S_COL, S_CDRAIN, S_DONE} state_t;

  localparam logic signed [WIDTH_Y-1:0] RND1 = WIDTH_Y'(2 ** (SHIFT1 - 1));
  localparam logic signed [WIDTH_Y-1:0] RND2 = WIDTH_Y'(2 ** (SHIFT2 - 1));

  state_t                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      load, in_rdy, tag_in_vld;
  logic [1:0]                tag_in_idx;
  logic                      tag1_vld_q, tag2_vld_q;
  logic [1:0]                tag1_idx_q, tag2_idx_q;
  logic signed [WIDTH_Y-1:0] tbuf_q [4][4];
  logic signed [WIDTH_Y-1:0] x_ext [4];
  logic signed [WIDTH_Y-1:0] y_in [4];
  logic signed [WIDTH_Y-1:0] opnd [4];
  logic signed [WIDTH_Y-1:0] out_y_q [4];
  logic                      out_valid_q;
  logic [1:0]                out_col_q;
  logic                      row_cap, col_cap;

  assign x_ext[0] = WIDTH_Y'(bus.in_x0);
  assign x_ext[1] = WIDTH_Y'(bus.in_x1);
  assign x_ext[2] = WIDTH_Y'(bus.in_x2);
  assign x_ext[3] = WIDTH_Y'(bus.in_x3);
  assign y_in[0]  = bus.bf_y0;
  assign y_in[1]  = bus.bf_y1;
  assign y_in[2]  = bus.bf_y2;
  assign y_in[3]  = bus.bf_y3;

  // The stage-2 tag belongs to the row phase until the row drain ends; afterwards it is a column.
  assign row_cap = load && tag2_vld_q && (state_q == S_ROW || state_q == S_RDRAIN);
  assign col_cap = load && tag2_vld_q && (state_q == S_COL || state_q == S_CDRAIN);

  // Next-state logic, butterfly strobe, operand mux and tag source.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    in_rdy     = 1'b0;
    tag_in_vld = 1'b0;
    tag_in_idx = cnt_q;
    for (int i = 0; i < 4; i++) opnd[i] = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ROW;
          cnt_d   = '0;
        end
      end
      S_ROW: begin
        in_rdy = 1'b1;
        for (int i = 0; i < 4; i++) opnd[i] = x_ext[i];
        if (bus.in_valid) begin
          load       = 1'b1;
          tag_in_vld = 1'b1;
          cnt_d      = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_RDRAIN;
        end
      end
      S_RDRAIN, S_CDRAIN: begin
        load  = 1'b1;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          cnt_d   = '0;
          state_d = (state_q == S_RDRAIN) ? S_COL : S_DONE;
        end
      end
      S_COL: begin
        load       = 1'b1;
        tag_in_vld = 1'b1;
        for (int r = 0; r < 4; r++) opnd[r] = tbuf_q[r][cnt_q];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_CDRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and phase counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tag pipe, transpose buffer and registered column output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag1_vld_q  <= 1'b0;
      tag1_idx_q  <= '0;
      tag2_vld_q  <= 1'b0;
      tag2_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      for (int r = 0; r < 4; r++) begin
        out_y_q[r] <= '0;
        for (int c = 0; c < 4; c++) tbuf_q[r][c] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (load) begin
        tag1_vld_q <= tag_in_vld;
        tag1_idx_q <= tag_in_idx;
        tag2_vld_q <= tag1_vld_q;
        tag2_idx_q <= tag1_idx_q;
      end
      if (row_cap) begin
        for (int c = 0; c < 4; c++) tbuf_q[tag2_idx_q][c] <= (y_in[c] + RND1) >>> SHIFT1;
      end
      if (col_cap) begin
        out_valid_q <= 1'b1;
        out_col_q   <= tag2_idx_q;
        for (int i = 0; i < 4; i++) out_y_q[i] <= (y_in[i] + RND2) >>> SHIFT2;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.bf_load   = load;
  assign bus.bf_x0     = opnd[0];
  assign bus.bf_x1     = opnd[1];
  assign bus.bf_x2     = opnd[2];
  assign bus.bf_x3     = opnd[3];
  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_y0    = out_y_q[0];
  assign bus.out_y1    = out_y_q[1];
  assign bus.out_y2    = out_y_q[2];
  assign bus.out_y3    = out_y_q[3];
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule
